// File: rtl/pe_array_execution_controller.sv
// PE array execution controller.
// Drives the broadcast reset/enable/execute controls of a PE array through a
// reset -> arm -> run -> finish sequence. It ends a run either on global
// termination (held for QUIESCENCE_CYCLES) or on an optional cycle timeout.
module pe_array_execution_controller #(
  parameter int NUM_PES           = 4,
  parameter int RESET_CYCLES      = 2,
  parameter int BLANKING_CYCLES   = 2,
  parameter int QUIESCENCE_CYCLES = 4,
  parameter int COUNTER_WIDTH     = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [COUNTER_WIDTH-1:0] timeout_limit,
  input  logic [NUM_PES-1:0]       pe_halted,
  input  logic [NUM_PES-1:0]       pe_channels_quiescent,
  input  logic [NUM_PES-1:0]       pe_router_quiescent,
  output logic                     pe_reset,
  output logic                     pe_enable,
  output logic                     pe_execute,
  output logic                     busy,
  output logic                     done,
  output logic                     timed_out,
  output logic [COUNTER_WIDTH-1:0] cycle_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RESET_PES = 3'd1;
  localparam logic [2:0] S_ARM       = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  localparam int RST_CNT_W = $clog2(RESET_CYCLES + 1);
  localparam int QUIES_W   = $clog2(QUIESCENCE_CYCLES + 1);

  localparam logic [RST_CNT_W-1:0]     RST_LAST   = RST_CNT_W'(RESET_CYCLES - 1);
  localparam logic [QUIES_W-1:0]       QUIES_LAST = QUIES_W'(QUIESCENCE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] BLANK_LEN  = COUNTER_WIDTH'(BLANKING_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE    = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX    = {COUNTER_WIDTH{1'b1}};

  logic [2:0]               state_q, state_d;
  logic [RST_CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [QUIES_W-1:0]       quies_q, quies_d;
  logic [COUNTER_WIDTH-1:0] limit_q, limit_d;
  logic [COUNTER_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic                     timed_out_q, timed_out_d;
  logic                     pe_reset_q, pe_reset_d;
  logic                     pe_enable_q, pe_enable_d;
  logic                     pe_execute_q, pe_execute_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic term;
  logic blanking;
  logic quiesced;
  logic timeout_hit;

  // Global termination and RUN-phase qualifiers.
  always_comb begin
    term        = (&pe_halted) & (&pe_channels_quiescent) & (&pe_router_quiescent);
    // cycle_count is cleared on every accepted start, so it doubles as the
    // RUN-cycle index for the blanking window.
    blanking    = (cycle_count_q < BLANK_LEN);
    // This cycle completes the required run of consecutive terminated cycles.
    quiesced    = !blanking && term && (quies_q == QUIES_LAST);
    timeout_hit = (limit_q != '0) && (cycle_count_q == (limit_q - CNT_ONE));
  end

  // Next-state, counter and latch logic; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    quies_d       = quies_q;
    limit_d       = limit_q;
    cycle_count_d = cycle_count_q;
    timed_out_d   = timed_out_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d       = S_RESET_PES;
            rst_cnt_d     = '0;
            limit_d       = timeout_limit;
            timed_out_d   = 1'b0;
            cycle_count_d = '0;
          end
        end
        S_RESET_PES: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d = S_ARM;
          end else begin
            rst_cnt_d = rst_cnt_q + 1'b1;
          end
        end
        S_ARM: begin
          state_d = S_RUN;
          quies_d = '0;
        end
        S_RUN: begin
          if (cycle_count_q != CNT_MAX) begin
            cycle_count_d = cycle_count_q + CNT_ONE;
          end
          if (blanking || !term) begin
            quies_d = '0;
          end else begin
            quies_d = quies_q + 1'b1;
          end
          // Termination takes precedence over a coincident timeout.
          if (quiesced) begin
            state_d     = S_FINISH;
            timed_out_d = 1'b0;
          end else if (timeout_hit) begin
            state_d     = S_FINISH;
            timed_out_d = 1'b1;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered and derived from the state being entered, so they
  // line up with that state in the following cycle.
  always_comb begin
    pe_reset_d   = (state_d == S_RESET_PES);
    pe_execute_d = (state_d == S_RUN);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FINISH);
    if (abort) begin
      pe_enable_d = 1'b0;
    end else if (state_d == S_IDLE) begin
      // Enable stays up after FINISH so the host can still read PE state.
      pe_enable_d = pe_enable_q;
    end else begin
      pe_enable_d = (state_d != S_RESET_PES);
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      quies_q       <= '0;
      cycle_count_q <= '0;
      timed_out_q   <= 1'b0;
      pe_reset_q    <= 1'b1;
      pe_enable_q   <= 1'b0;
      pe_execute_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      quies_q       <= quies_d;
      cycle_count_q <= cycle_count_d;
      timed_out_q   <= timed_out_d;
      pe_reset_q    <= pe_reset_d;
      pe_enable_q   <= pe_enable_d;
      pe_execute_q  <= pe_execute_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Latched timeout limit; only consulted during RUN, after a start has loaded it.
  always_ff @(posedge clock) begin
    limit_q <= limit_d;
  end

  assign pe_reset    = pe_reset_q;
  assign pe_enable   = pe_enable_q;
  assign pe_execute  = pe_execute_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pe_array_execution_controller.sv
// Testbench for pe_array_execution_controller: directed scenarios checked
// every cycle against a timeline-based behavioural model, plus literal checks.
module tb_pe_array_execution_controller;

  localparam int NP = 4;
  localparam int RC = 2;
  localparam int BC = 2;
  localparam int QC = 4;
  localparam int CW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] timeout_limit = '0;
  logic [NP-1:0] halted = '0;
  logic [NP-1:0] chq = '0;
  logic [NP-1:0] rtq = '0;
  logic          pe_reset, pe_enable, pe_execute, busy, done, timed_out;
  logic [CW-1:0] cycle_count;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  pe_array_execution_controller #(
    .NUM_PES(NP), .RESET_CYCLES(RC), .BLANKING_CYCLES(BC),
    .QUIESCENCE_CYCLES(QC), .COUNTER_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .timeout_limit(timeout_limit), .pe_halted(halted),
    .pe_channels_quiescent(chq), .pe_router_quiescent(rtq),
    .pe_reset(pe_reset), .pe_enable(pe_enable), .pe_execute(pe_execute),
    .busy(busy), .done(done), .timed_out(timed_out), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  // Model: a run is described by k = cycles since the accepted start.
  // k < RC: PE reset; k == RC: arm; k > RC: run cycle number m_cnt.
  bit     m_active, m_fin, m_prst, m_en, m_to;
  int     m_k, m_streak;
  longint m_cnt, m_limit;
  bit     e_rst, e_en, e_ex;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit term;
    if (reset) begin
      m_active = 0; m_fin = 0; m_prst = 1; m_en = 0; m_to = 0;
      m_cnt = 0; m_streak = 0; m_k = 0;
    end else begin
      m_prst = 0;
      if (abort) begin
        m_active = 0; m_fin = 0; m_en = 0;
      end else if (m_fin) begin
        m_fin = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_k = 0; m_to = 0; m_cnt = 0;
          m_limit = timeout_limit; m_streak = 0;
        end
      end else begin
        if (m_k > RC) begin
          term = (&halted) && (&chq) && (&rtq);
          if (m_cnt < BC) m_streak = 0;
          else m_streak = term ? m_streak + 1 : 0;
          if (m_streak == QC) begin
            m_fin = 1; m_active = 0; m_to = 0;
          end else if (m_limit != 0 && m_cnt == m_limit - 1) begin
            m_fin = 1; m_active = 0; m_to = 1;
          end
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
        m_k++;
      end
    end
    e_rst = m_prst || (m_active && m_k < RC);
    e_ex  = m_active && m_k > RC;
    if (m_fin || (m_active && m_k >= RC)) e_en = 1;
    else if (m_active) e_en = 0;
    else e_en = m_en;
    m_en = e_en;
  endtask

  // One clock: advance the model on the same inputs, then compare every output.
  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    if (done) done_seen++;
    chk("pe_reset", pe_reset, e_rst);
    chk("pe_enable", pe_enable, e_en);
    chk("pe_execute", pe_execute, e_ex);
    chk("busy", busy, m_active || m_fin);
    chk("done", done, m_fin);
    chk("timed_out", timed_out, m_to);
    chk("cycle_count", cycle_count, m_cnt);
  endtask

  task automatic set_status(input int pat, input int r);
    case (pat)
      0: begin halted = (r >= 10) ? '1 : '0; chq = halted; rtq = halted; end
      1: begin halted = '1; chq = '1; rtq = '1; if (r == 5) rtq[2] = 1'b0; end
      default: begin halted = '0; chq = '1; rtq = '1; end
    endcase
  endtask

  // Accepted start, then wait for pe_execute; reports latency and reset width.
  task automatic launch(input int limit, output int lat, output int rst_hi);
    timeout_limit = limit;
    halted = '0; chq = '0; rtq = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    rst_hi = pe_reset ? 1 : 0;
    while (!pe_execute && lat < 50) begin
      tick();
      lat++;
      if (pe_reset) rst_hi++;
    end
  endtask

  // Run cycles with a status pattern until done or idle (bounded).
  task automatic run(input int pat, input int start_at, input int abort_at,
                     input int reset_at, output int nrun);
    nrun = 0;
    for (int r = 0; r < 200; r++) begin
      set_status(pat, r);
      start = (r == start_at);
      abort = (r == abort_at);
      reset = (r == reset_at);
      tick();
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      nrun = r + 1;
      if (done || !busy) break;
    end
  endtask

  initial begin
    int lat, rh, n, d0;
    // Reset state
    tick(); tick();
    chk("reset_pe_reset", pe_reset, 1);
    chk("reset_busy", busy, 0);
    chk("reset_cycle_count", cycle_count, 0);
    reset = 1'b0;
    tick();
    chk("idle_pe_reset", pe_reset, 0);

    // Normal run
    d0 = done_seen;
    launch(0, lat, rh);
    chk("normal_latency", lat, RC + 2);
    chk("normal_reset_width", rh, RC);
    run(0, -1, -1, -1, n);
    chk("normal_done", done, 1);
    chk("normal_cycles", cycle_count, 14);
    chk("normal_timed_out", timed_out, 0);
    tick();
    chk("normal_busy_after", busy, 0);
    chk("normal_enable_held", pe_enable, 1);
    chk("normal_done_pulses", done_seen - d0, 1);

    // Glitch after blanking, plus an ignored start mid-run
    launch(0, lat, rh);
    run(1, 3, -1, -1, n);
    chk("glitch_cycles", cycle_count, 10);
    tick();

    // Timeout
    launch(20, lat, rh);
    run(2, -1, -1, -1, n);
    chk("timeout_cycles", cycle_count, 20);
    chk("timeout_flag", timed_out, 1);
    tick();
    chk("timeout_sticky", timed_out, 1);

    // Next start clears timed_out; termination coincides with timeout
    launch(14, lat, rh);
    chk("restart_clears_to", timed_out, 0);
    run(0, -1, -1, -1, n);
    chk("tie_cycles", cycle_count, 14);
    chk("tie_timed_out", timed_out, 0);
    tick();

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    tick();

    // Abort mid-run at cycle_count 7
    d0 = done_seen;
    launch(0, lat, rh);
    run(2, -1, 7, -1, n);
    chk("abort_busy", busy, 0);
    chk("abort_enable", pe_enable, 0);
    chk("abort_execute", pe_execute, 0);
    chk("abort_count", cycle_count, 7);
    tick(); tick();
    chk("abort_no_done", done_seen - d0, 0);

    // Synchronous reset mid-run, then a fresh run
    launch(0, lat, rh);
    run(2, -1, -1, 5, n);
    chk("midreset_pe_reset", pe_reset, 1);
    chk("midreset_execute", pe_execute, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_count", cycle_count, 0);
    tick();
    d0 = done_seen;
    launch(0, lat, rh);
    chk("fresh_latency", lat, RC + 2);
    run(0, -1, -1, -1, n);
    chk("fresh_cycles", cycle_count, 14);
    tick();
    chk("fresh_done_pulses", done_seen - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_array_execution_controller.md
Name: pe_array_execution_controller

Overview:
- Sequences the reset/enable/execute control of an array of NUM_PES processing elements.
- Each PE registers its control inputs and status outputs one cycle each.
- Detects global termination: all PEs halted, all channel buffers quiescent and all router buffers quiescent, stable for QUIESCENCE_CYCLES.
- Enforces an optional cycle timeout and reports completion to the host-side control logic.

Parameters:
NUM_PES, 4, number of PEs driven and monitored (>=1)
RESET_CYCLES, 2, cycles pe_reset is held high per run (>=1)
BLANKING_CYCLES, 2, RUN cycles during which status is ignored (covers the PE in/out buffering round trip)
QUIESCENCE_CYCLES, 4, consecutive cycles of global termination required (>=1)
COUNTER_WIDTH, 32, width of cycle_count and timeout_limit

Ports:
clock  in  1  positive-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle run request; honoured only in IDLE
abort  in  1  terminates any run immediately
timeout_limit  in  COUNTER_WIDTH  max RUN cycles; 0 = no timeout; sampled on accepted start
pe_halted  in  NUM_PES  per-PE halted status
pe_channels_quiescent  in  NUM_PES  per-PE channel-buffer quiescence
pe_router_quiescent  in  NUM_PES  per-PE router-buffer quiescence
pe_reset  out  1  broadcast PE reset
pe_enable  out  1  broadcast PE enable
pe_execute  out  1  broadcast PE execute
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on run completion (normal or timeout)
timed_out  out  1  sticky: last run ended by timeout; cleared on accepted start
cycle_count  out  COUNTER_WIDTH  cycles spent in RUN for the current/last run

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: pe_reset=1, pe_enable=0, pe_execute=0, busy=0, done=0, timed_out=0, cycle_count=0. State=IDLE.
- States: IDLE, RESET_PES, ARM, RUN, FINISH.
- IDLE:
  - pe_reset=0, pe_execute=0; pe_enable holds its prior value.
  - An accepted start (start=1, abort=0) does the following on the next edge: enters RESET_PES, latches timeout_limit, clears timed_out and cycle_count.
- RESET_PES: pe_reset=1, pe_enable=0, pe_execute=0 for exactly RESET_CYCLES cycles, then ARM.
- ARM: pe_reset=0, pe_enable=1, pe_execute=0 for exactly 1 cycle, then RUN.
- RUN:
  - Outputs: pe_enable=1, pe_execute=1.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - Blanking: during the first BLANKING_CYCLES RUN cycles, the quiescence counter is forced to 0.
  - Termination term = &pe_halted & &pe_channels_quiescent & &pe_router_quiescent.
  - After blanking, the quiescence counter increments when term=1 and clears to 0 when term=0.
  - When the counter reaches QUIESCENCE_CYCLES, the next state is FINISH with timed_out=0.
  - Timeout: latched limit !=0 and cycle_count == limit-1 in a RUN cycle -> next state FINISH, timed_out=1. Exactly `limit` RUN cycles elapse.
  - Termination and timeout in the same cycle: termination wins, timed_out=0.
- FINISH: pe_execute=0, pe_enable=1, done=1 for exactly 1 cycle, then IDLE. pe_enable stays 1 so the host can read PE state.
- abort=1 in any state:
  - Next state is IDLE; pe_execute=0, pe_enable=0, pe_reset=0.
  - No done pulse; timed_out unchanged; cycle_count holds.
  - abort has priority over start and over every RUN transition.
- start while busy: ignored; no state, counter or latch changes.
- Start-to-execute latency: start at edge N -> pe_reset high at N+1..N+RESET_CYCLES -> pe_execute first high at N+RESET_CYCLES+2.
- reset mid-run: on the next edge all state and outputs return to reset values, including pe_reset=1.

Test Plan:
- Normal run: defaults, timeout_limit=0. Start; all status bits go high 10 cycles after pe_execute rises and stay high -> pe_reset high for 2 cycles; pe_execute high; done pulses once; cycle_count=14; timed_out=0; busy low the cycle after done.
- Glitch and blanking: status all-high during blanking and for 3 cycles after it, then pe_router_quiescent[2]=0 for 1 cycle, then all-high -> quiescence counter restarts; FINISH is entered only after 4 further consecutive all-high cycles.
- Timeout: timeout_limit=20, pe_halted=0 throughout -> exactly 20 RUN cycles; cycle_count=20; timed_out=1; done pulse. A subsequent start clears timed_out to 0.
- Simultaneous events:
  - Termination and timeout in the same cycle -> timed_out=0.
  - start and abort together in IDLE -> stays IDLE.
  - start during RUN -> ignored.
- Abort mid-RUN at cycle_count=7 -> next cycle IDLE with pe_execute=0 and pe_enable=0; no done pulse; cycle_count=7.
- Synchronous reset asserted during RUN -> next edge pe_reset=1, pe_execute=0, busy=0, cycle_count=0. A fresh start then completes normally.
